mem_stage: RTL

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/riscv_pkg.sv | 21 ++
 rtl/mem_wb_reg.sv | 19 +
 rtl/mem_stage.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared widths, the MEM-stage state type and the MEM/WB register layout.
package riscv_pkg;

  localparam int XLEN             = 32;
  localparam int REGADDR          = 5;
  localparam int MAX_WAIT_DEFAULT = 15;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_t;

  typedef struct packed {
    logic               mem_to_reg;
    logic               reg_write;
    logic [XLEN-1:0]    read_data;
    logic [XLEN-1:0]    alu_result;
    logic [REGADDR-1:0] rd_addr;
  } mem_wb_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register; loads every edge, hold/bubble decisions live in the stage mux.
module mem_wb_reg
  import riscv_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  mem_wb_t d,
  output mem_wb_t q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: issues one data-bus access at a time, stalls upstream until
// ack, aborts on misalignment or after MAX_WAIT busy cycles.
module mem_stage
  import riscv_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               MemtoReg_mem,
  input  logic               RegWrite_mem,
  input  logic               MemWrite_mem,
  input  logic [XLEN-1:0]    ALUResult_mem,
  input  logic [XLEN-1:0]    MemWriteData_mem,
  input  logic [REGADDR-1:0] rdAddr_mem,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [XLEN-1:0]    dmem_addr,
  output logic [XLEN-1:0]    dmem_wdata,
  input  logic [XLEN-1:0]    dmem_rdata,
  input  logic               dmem_ack,
  output logic               stall_mem,
  output logic               mem_err,
  output logic               MemtoReg_wb,
  output logic               RegWrite_wb,
  output logic [XLEN-1:0]    MemReadData_wb,
  output logic [XLEN-1:0]    ALUResult_wb,
  output logic [REGADDR-1:0] rdAddr_wb
);

  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT - 1);

  mem_state_t         state, state_next;
  logic [3:0]         wait_cnt;
  logic [XLEN-1:0]    addr_q, wdata_q;
  logic [REGADDR-1:0] rd_q;
  logic               we_q, mem_to_reg_q, reg_write_q;
  logic               err_q, err_next, latch_access;
  logic               is_access, aligned, busy, timeout;
  mem_wb_t            wb_q, wb_next;

  assign is_access = MemtoReg_mem | MemWrite_mem;
  assign aligned   = (ALUResult_mem[1:0] == 2'b00);
  assign busy      = (state == BUSY);
  assign timeout   = busy && !dmem_ack && (wait_cnt == WAIT_LIMIT);

  // Bubbles clear only the writeback controls; the data fields simply hold.
  always_comb begin
    state_next           = state;
    stall_mem            = 1'b0;
    err_next             = 1'b0;
    latch_access         = 1'b0;
    wb_next.mem_to_reg   = 1'b0;
    wb_next.reg_write    = 1'b0;
    wb_next.read_data    = wb_q.read_data;
    wb_next.alu_result   = wb_q.alu_result;
    wb_next.rd_addr      = wb_q.rd_addr;
    case (state)
      IDLE: begin
        if (is_access) begin
          if (aligned) begin
            latch_access = 1'b1;
            state_next   = BUSY;
            stall_mem    = 1'b1;
          end else begin
            err_next = 1'b1;
          end
        end else begin
          wb_next.reg_write  = RegWrite_mem;
          wb_next.alu_result = ALUResult_mem;
          wb_next.rd_addr    = rdAddr_mem;
        end
      end
      BUSY: begin
        if (dmem_ack) begin
          state_next         = IDLE;
          wb_next.mem_to_reg = mem_to_reg_q;
          wb_next.reg_write  = reg_write_q & ~we_q;
          wb_next.read_data  = mem_to_reg_q ? dmem_rdata : wb_q.read_data;
          wb_next.alu_result = addr_q;
          wb_next.rd_addr    = rd_q;
        end else if (timeout) begin
          state_next = IDLE;
          err_next   = 1'b1;
        end else begin
          stall_mem = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      err_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rd_q         <= '0;
      we_q         <= 1'b0;
      mem_to_reg_q <= 1'b0;
      reg_write_q  <= 1'b0;
    end else begin
      state <= state_next;
      err_q <= err_next;
      if (busy && state_next == BUSY) begin
        if (wait_cnt != 4'hF) begin
          wait_cnt <= wait_cnt + 4'd1;
        end
      end else begin
        wait_cnt <= '0;
      end
      if (latch_access) begin
        addr_q       <= ALUResult_mem;
        wdata_q      <= MemWriteData_mem;
        rd_q         <= rdAddr_mem;
        we_q         <= MemWrite_mem;
        mem_to_reg_q <= MemtoReg_mem;
        reg_write_q  <= RegWrite_mem;
      end
    end
  end

  mem_wb_reg u_mem_wb_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (wb_next),
    .q     (wb_q)
  );

  // Request follows the state so an async reset drops it immediately.
  assign dmem_req       = busy;
  assign dmem_we        = busy & we_q;
  assign dmem_addr      = addr_q;
  assign dmem_wdata     = wdata_q;
  assign mem_err        = err_q;
  assign MemtoReg_wb    = wb_q.mem_to_reg;
  assign RegWrite_wb    = wb_q.reg_write;
  assign MemReadData_wb = wb_q.read_data;
  assign ALUResult_wb   = wb_q.alu_result;
  assign rdAddr_wb      = wb_q.rd_addr;

endmodule
